replay_rd_seq: RTL and testbench

//  Read-side sequencer for the replay memory: fetches a batch of stored entries over a
//  1-cycle-latency synchronous read port and streams them out on a valid/ready interface.

---
 rtl/rl_mem_pkg.sv | 9 +
 rtl/skid_buf2.sv | 54 +++++
 rtl/replay_rd_seq.sv | 132 +++++++++++++
 tb/tb_replay_rd_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rl_mem_pkg.sv
// Shared types for the replay memory read-side logic.
// Holds the read sequencer state encoding and the output buffer depth.
package rl_mem_pkg;

    typedef enum logic [1:0] {RD_IDLE, RD_RUN, RD_DRAIN} rd_state_t;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry valid/ready buffer with an empty-bypass path and a synchronous flush.
// Zero-cycle bypass when empty; the upstream must only send when occ plus in-flight is below 2.
module skid_buf2 #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occ
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic         push;
    logic         pop;

    // Incoming data only lands in storage when it cannot be handed straight through.
    assign push      = in_valid && !(cnt == 2'd0 && out_ready);
    assign pop       = (cnt != 2'd0) && out_ready;
    assign out_valid = (cnt != 2'd0) || in_valid;
    assign out_data  = (cnt != 2'd0) ? mem[rd_ptr] : (in_valid ? in_data : '0);
    assign occ       = cnt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/replay_rd_seq.sv
// Replay memory read sequencer: issues batch reads with fill-count wrap and streams entries out.
// First entry 2 cycles after start, then 1/cycle; reads throttled by 2-entry buffer credit under backpressure.
module replay_rd_seq
    import rl_mem_pkg::*;
#(
    parameter int WL = 16,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          start,
    input  logic          abort,
    input  logic [WL-1:0] start_idx,
    input  logic [WL-1:0] batch_len,
    input  logic [WL-1:0] fill_cnt,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          mem_ren,
    output logic [WL-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last
);

    rd_state_t     state, state_nxt;
    logic [WL-1:0] fill_snap;
    logic [WL-1:0] len_snap;
    logic [WL-1:0] addr;
    logic [WL-1:0] issued;
    logic          inflight;
    logic          inflight_last;
    logic          done_q;
    logic          err_q;
    logic          issue;
    logic          issue_last;
    logic          credit_ok;
    logic          launch;
    logic          flush;
    logic          xfer_last;
    logic [1:0]    occ;

    assign launch     = (state == RD_IDLE) && start && !abort;
    assign flush      = abort && (state != RD_IDLE);
    assign issue_last = (issued + WL'(1)) == len_snap;
    // Buffered plus in-flight entries must leave room for the read about to be issued.
    assign credit_ok  = (3'(occ) + 3'(inflight)) < 3'(SKID_DEPTH);
    assign xfer_last  = out_valid && out_ready && out_last;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            RD_IDLE: begin
                if (launch && fill_cnt != '0 && batch_len != '0) begin
                    state_nxt = RD_RUN;
                end
            end
            RD_RUN: begin
                if (abort) begin
                    state_nxt = RD_IDLE;
                end else if (credit_ok) begin
                    issue = 1'b1;
                    if (issue_last) begin
                        state_nxt = RD_DRAIN;
                    end
                end
            end
            RD_DRAIN: begin
                if (abort || xfer_last) begin
                    state_nxt = RD_IDLE;
                end
            end
            default: state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state         <= RD_IDLE;
            fill_snap     <= '0;
            len_snap      <= '0;
            addr          <= '0;
            issued        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state         <= state_nxt;
            inflight      <= issue;
            inflight_last <= issue && issue_last;
            done_q        <= (state == RD_DRAIN) && !abort && xfer_last;
            err_q         <= 1'b0;
            if (launch) begin
                fill_snap <= fill_cnt;
                len_snap  <= batch_len;
                issued    <= '0;
                addr      <= (start_idx < fill_cnt) ? start_idx : '0;
                err_q     <= (fill_cnt == '0);
                done_q    <= (fill_cnt != '0) && (batch_len == '0);
            end
            if (issue) begin
                issued <= issued + WL'(1);
                addr   <= (addr == fill_snap - WL'(1)) ? '0 : addr + WL'(1);
            end
        end
    end

    skid_buf2 #(
        .W (DW + 1)
    ) u_buf (
        .clk       (clk),
        .rst_b     (rst_b),
        .flush     (flush),
        .in_valid  (inflight),
        .in_data   ({inflight_last, mem_rdata}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  ({out_last, out_data}),
        .occ       (occ)
    );

    assign busy      = (state != RD_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign mem_ren   = issue;
    assign mem_raddr = addr;

endmodule

// File: tb/tb_replay_rd_seq.sv
// Directed bench for replay_rd_seq with a wrap-order address model and per-cycle output checking.
module tb_replay_rd_seq;

    localparam int WL = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [WL-1:0] start_idx = '0;
    logic [WL-1:0] batch_len = '0;
    logic [WL-1:0] fill_cnt = '0;
    logic          busy, done, err, mem_ren;
    logic [WL-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;

    replay_rd_seq #(.WL(WL), .DW(DW)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .start     (start),
        .abort     (abort),
        .start_idx (start_idx),
        .batch_len (batch_len),
        .fill_cnt  (fill_cnt),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_ren   (mem_ren),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Synchronous memory: each entry holds a tag plus its own address.
    always @(posedge clk) if (mem_ren) mem_rdata <= {16'hDA7A, mem_raddr};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model state
    int exp_addr[$];
    int got_addr[$];
    int exp_len = 0;
    int iss_idx, xfer_idx, done_cnt, err_cnt, last_cnt;
    int first_ren_cyc, last_ren_cyc, first_val_cyc, last_xfer_cyc, done_cyc, start_cyc;
    logic          stalled = 1'b0;
    logic [DW-1:0] hold_data;
    logic          hold_last;

    task automatic arm(input int fill, input int sidx, input int len);
        int base;
        base = (sidx < fill) ? sidx : 0;
        exp_addr.delete();
        got_addr.delete();
        for (int k = 0; k < len; k++) if (fill > 0) exp_addr.push_back((base + k) % fill);
        exp_len = (fill > 0) ? len : 0;
        iss_idx = 0; xfer_idx = 0; done_cnt = 0; err_cnt = 0; last_cnt = 0;
        first_ren_cyc = -1; last_ren_cyc = -1; first_val_cyc = -1;
        last_xfer_cyc = -1; done_cyc = -1;
        stalled = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_b) begin
            stalled = 1'b0;
        end else begin
            if (mem_ren) begin
                if (first_ren_cyc < 0) first_ren_cyc = cyc;
                last_ren_cyc = cyc;
                got_addr.push_back(int'(mem_raddr));
                if (iss_idx < exp_len) chk("raddr", mem_raddr, exp_addr[iss_idx]);
                else chk("over_issue", iss_idx, exp_len);
                iss_idx++;
                chk("credit", (iss_idx - xfer_idx) <= 2, 1);
            end
            if (out_valid) begin
                if (first_val_cyc < 0) first_val_cyc = cyc;
                if (stalled) begin
                    chk("stall_data", out_data, hold_data);
                    chk("stall_last", out_last, hold_last);
                end
                if (out_ready) begin
                    if (xfer_idx < exp_len) begin
                        chk("out_data", out_data, {16'hDA7A, 16'(exp_addr[xfer_idx])});
                        chk("out_last", out_last, xfer_idx == exp_len - 1);
                    end else begin
                        chk("over_deliver", xfer_idx, exp_len);
                    end
                    if (out_last) last_cnt++;
                    last_xfer_cyc = cyc;
                    xfer_idx++;
                end
                hold_data = out_data;
                hold_last = out_last;
            end else if (stalled) begin
                chk("stall_valid", out_valid, 1);
            end
            stalled = out_valid && !out_ready && !abort;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (err) err_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ready_val(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (c >= 4 && c < 9) return 1'b0;
        return (c % 2) == 0;
    endfunction

    task automatic launch(input int fill, input int sidx, input int len, input int mode);
        arm(fill, sidx, len);
        start = 1'b1; start_idx = WL'(sidx); batch_len = WL'(len); fill_cnt = WL'(fill);
        out_ready = ready_val(mode, 0);
        start_cyc = cyc;
        tick();
        start = 1'b0;
        fill_cnt = WL'(3);  // must be ignored until the next start
    endtask

    task automatic run_batch(input string tag, input int fill, input int sidx, input int len,
                             input int mode, input int exp_done, input int exp_err);
        int n;
        launch(fill, sidx, len, mode);
        n = 1;
        while (done_cnt == 0 && err_cnt == 0 && n < 300) begin
            out_ready = ready_val(mode, n);
            tick();
            n++;
        end
        out_ready = 1'b1;
        repeat (3) tick();
        chk({tag, "_xfers"}, xfer_idx, (exp_err != 0) ? 0 : len);
        chk({tag, "_issues"}, iss_idx, (exp_err != 0) ? 0 : len);
        chk({tag, "_done"}, done_cnt, exp_done);
        chk({tag, "_err"}, err_cnt, exp_err);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int lit1[4] = '{2, 3, 4, 5};
        int lit2[7] = '{3, 4, 0, 1, 2, 3, 4};
        int n;
        int iss_at_abort;

        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_ren", mem_ren, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_done_err", {done, err}, 0);
        rst_b = 1'b1;
        tick();

        // Full throughput with timing pins
        run_batch("t1", 8, 2, 4, 0, 1, 0);
        chk("t1_ren_lat", first_ren_cyc - start_cyc, 1);
        chk("t1_val_lat", first_val_cyc - start_cyc, 2);
        chk("t1_ren_span", last_ren_cyc - first_ren_cyc, 3);
        chk("t1_done_lat", done_cyc - last_xfer_cyc, 1);
        for (int i = 0; i < 4; i++) chk("t1_addr_lit", got_addr[i], lit1[i]);

        // Wrap past fill count
        run_batch("t2", 5, 3, 7, 0, 1, 0);
        for (int i = 0; i < 7; i++) chk("t2_addr_lit", got_addr[i], lit2[i]);
        chk("t2_last_cnt", last_cnt, 1);

        // Backpressure pattern
        run_batch("t3", 8, 1, 6, 1, 1, 0);
        chk("t3_last_cnt", last_cnt, 1);

        // Start index beyond fill wraps to 0
        run_batch("t3b", 4, 9, 3, 0, 1, 0);

        // Degenerate starts
        run_batch("t4_fill0", 0, 0, 4, 0, 0, 1);
        run_batch("t4_len0", 8, 0, 0, 0, 1, 0);

        // Start and abort together in IDLE
        arm(8, 0, 4);
        start = 1'b1; abort = 1'b1; start_idx = '0; batch_len = WL'(4); fill_cnt = WL'(8);
        tick();
        start = 1'b0; abort = 1'b0;
        repeat (3) tick();
        chk("t5_idle_abort_busy", busy, 0);
        chk("t5_idle_abort_iss", iss_idx, 0);

        // Abort after third transfer
        launch(8, 0, 10, 0);
        out_ready = 1'b1;
        n = 0;
        while (xfer_idx < 3 && n < 50) begin tick(); n++; end
        chk("t6_reach3", xfer_idx, 3);
        abort = 1'b1; out_ready = 1'b0;
        tick();
        abort = 1'b0;
        chk("t6_valid_off", out_valid, 0);
        chk("t6_busy_off", busy, 0);
        iss_at_abort = iss_idx;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("t6_no_more_xfer", xfer_idx, 3);
        chk("t6_no_more_iss", iss_idx, iss_at_abort);
        chk("t6_no_done", done_cnt, 0);
        run_batch("t6_after", 8, 6, 5, 0, 1, 0);

        // Asynchronous reset mid-batch
        launch(8, 0, 10, 0);
        repeat (3) tick();
        #3;
        rst_b = 1'b0;
        #1;
        chk("t7_busy", busy, 0);
        chk("t7_done", done, 0);
        chk("t7_err", err, 0);
        chk("t7_ren", mem_ren, 0);
        chk("t7_raddr", mem_raddr, 0);
        chk("t7_valid", out_valid, 0);
        chk("t7_data", out_data, 0);
        chk("t7_last", out_last, 0);
        repeat (2) tick();
        rst_b = 1'b1;
        tick();
        run_batch("t7_after", 8, 7, 4, 1, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
